fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the 5-stage MIPS pipeline. It serves NSRC decode-stage register read ports and optional HI/LO reads. For each read it resolves the youngest in-flight producer in EXE or MEM and returns bypass data, or holds decode with a stall until the data exists. Unlike the fixed two-port unit it replaces, it supports multi-cycle loads through a MEM data-valid flag, excludes $zero, accepts a flush, and counts stall cycles for performance monitoring.

## Interface
- DW, 32, data width of GPR/HI/LO values
- AW, 5, register index width
- NSRC, 2, number of decode read ports (1..4)
- HILO_EN, 1, 1 = HI/LO forwarding present; 0 = hi/lo outputs tied to reset values
- ZERO_REG, 1, 1 = index 0 never matches a producer
- CNT_W, 16, stall counter width
- clk_sig  in  1  clock; all state updates on the falling edge
- rst_sig  in  1  synchronous, active-high reset, sampled on the falling edge
- flush_in  in  1  pipeline flush; cancels stall and forward flags
- src_rena  in  NSRC  per-port read enable
- src_idx  in  NSRC*AW  per-port register index; port i is bits [i*AW +: AW]
- id_rd_hi, id_rd_lo  in  1 each  decode instruction reads HI / LO
- exe_rd_wena, exe_is_load  in  1 each  EXE writes GPR; EXE instruction is a load
- exe_rd_idx  in  AW  EXE destination register
- exe_rd_data  in  DW  EXE result
- exe_hi_wena, exe_lo_wena  in  1 each  EXE writes HI / LO
- exe_hi_data, exe_lo_data  in  DW each  EXE HI / LO results
- mem_rd_wena, mem_rd_valid  in  1 each  MEM writes GPR; MEM result is available (0 while a load is pending)
- mem_rd_idx  in  AW  MEM destination register
- mem_rd_data  in  DW  MEM result
- mem_hi_wena, mem_lo_wena  in  1 each  MEM writes HI / LO
- mem_hi_data, mem_lo_data  in  DW each  MEM HI / LO results
- stall_out  out  1  hold PC/IF/ID and insert an EXE bubble
- forward_out  out  1  any forward or hazard this cycle
- src_fwd_out  out  NSRC  port i takes src_data_out instead of the register file
- src_data_out  out  NSRC*DW  bypass data per port
- hi_fwd_out, lo_fwd_out  out  1 each  HI / LO bypass valid
- hi_data_out, lo_data_out  out  DW each  HI / LO bypass data
- stall_cnt_out  out  CNT_W  saturating count of stalled cycles

## Operation
- Reset: every output is 0, including the stall counter.
- Flush: when flush_in=1 and reset is not asserted, the edge clears stall_out, forward_out, src_fwd_out, hi_fwd_out and lo_fwd_out. Data outputs hold. The stall counter does not increment on that edge.
- Per-port resolution, evaluated each edge from the current inputs. Port i is active when src_rena[i]=1 and, if ZERO_REG=1, src_idx[i]≠0.
  - EXE match (exe_rd_wena and exe_rd_idx==src_idx[i]) with exe_is_load=1: hazard_i=1, src_fwd[i]=0.
  - EXE match with exe_is_load=0: src_fwd[i]=1, src_data[i]=exe_rd_data.
  - Otherwise MEM match (mem_rd_wena and mem_rd_idx==src_idx[i]) with mem_rd_valid=1: src_fwd[i]=1, src_data[i]=mem_rd_data.
  - MEM match with mem_rd_valid=0: hazard_i=1.
  - No match or inactive port: src_fwd[i]=0; src_data[i] holds its previous value.
  - EXE has priority over MEM, because EXE holds the younger producer.
- stall_out next value = OR of all hazard_i. The unit has no one-shot capture: each stalled cycle re-evaluates. The bubble moves the load from EXE to MEM, then mem_rd_valid releases the stall.
- HI/LO (HILO_EN=1):
  - id_rd_hi=1: exe_hi_wena selects exe_hi_data; otherwise mem_hi_wena selects mem_hi_data. hi_fwd_out is set when either is selected.
  - id_rd_lo works the same way for LO.
  - HI/LO never stall. Unselected HI/LO data holds.
- forward_out = OR(src_fwd) | hi_fwd | lo_fwd | stall.
- stall_cnt_out increments on each edge where the new stall_out=1 and saturates at 2^CNT_W−1.

## Timing
- Registered outputs update on the falling edge of clk_sig. Decode and the pipeline registers use them on the following rising edge, giving half-cycle latency.
- Single-cycle load (mem_rd_valid=1 on arrival in MEM): load-use costs exactly 1 stall cycle. The next edge forwards mem_rd_data.
- A load that waits k cycles in MEM with mem_rd_valid=0 costs 1+k stall cycles.
- Reset dominates flush; flush dominates hazard evaluation.
- Both ports may hit the same or different producers on the same edge. Results are independent per port; stall is the OR.
- Inputs are sampled only at the edge. Glitches between edges have no effect.

## Test plan
- Reset: rst_sig=1 for 2 edges -> all outputs 0, stall_cnt_out=0.
- EXE ALU forward with both ports: src_idx={5,5}, exe_rd_wena=1, exe_rd_idx=5, exe_rd_data=0x1234 -> src_fwd_out=2'b11, both data=0x1234, stall_out=0.
- EXE/MEM priority and zero register:
  - EXE and MEM both write r7 (0xAAAA / 0xBBBB) -> port gets 0xAAAA.
  - src_idx=0 with exe_rd_idx=0 -> src_fwd_out=0.
- Load-use, single cycle: exe_is_load=1, exe_rd_idx=3, port1 reads r3 -> stall_out=1. Next edge, load in MEM with mem_rd_valid=1 and data 0xDEAD -> stall_out=0, port1 data 0xDEAD, stall_cnt_out=1.
- Multi-cycle load: as above, but mem_rd_valid=0 for 3 edges -> stall_out high for 4 edges, stall_cnt_out=4. Flush on the 2nd stalled edge instead -> stall_out=0 immediately.
- HI/LO: id_rd_hi=1, exe_hi_wena=1 (0x11), mem_hi_wena=1 (0x22) -> hi_data_out=0x11, hi_fwd_out=1. With HILO_EN=0 -> hi_fwd_out stays 0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Resolves the youngest EXE/MEM producer for each decode read port and HI/LO,
// returns bypass data or requests a decode stall. State updates on the falling edge.
module fwd_hazard_unit #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned HILO_EN  = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk_sig,
  input  logic                 rst_sig,
  input  logic                 flush_in,
  input  logic [NSRC-1:0]      src_rena,
  input  logic [NSRC*AW-1:0]   src_idx,
  input  logic                 id_rd_hi,
  input  logic                 id_rd_lo,
  input  logic                 exe_rd_wena,
  input  logic                 exe_is_load,
  input  logic [AW-1:0]        exe_rd_idx,
  input  logic [DW-1:0]        exe_rd_data,
  input  logic                 exe_hi_wena,
  input  logic                 exe_lo_wena,
  input  logic [DW-1:0]        exe_hi_data,
  input  logic [DW-1:0]        exe_lo_data,
  input  logic                 mem_rd_wena,
  input  logic                 mem_rd_valid,
  input  logic [AW-1:0]        mem_rd_idx,
  input  logic [DW-1:0]        mem_rd_data,
  input  logic                 mem_hi_wena,
  input  logic                 mem_lo_wena,
  input  logic [DW-1:0]        mem_hi_data,
  input  logic [DW-1:0]        mem_lo_data,
  output logic                 stall_out,
  output logic                 forward_out,
  output logic [NSRC-1:0]      src_fwd_out,
  output logic [NSRC*DW-1:0]   src_data_out,
  output logic                 hi_fwd_out,
  output logic                 lo_fwd_out,
  output logic [DW-1:0]        hi_data_out,
  output logic [DW-1:0]        lo_data_out,
  output logic [CNT_W-1:0]     stall_cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [AW-1:0]      idx_c [NSRC];
  logic [NSRC-1:0]    act_c;
  logic [NSRC-1:0]    exe_hit_c;
  logic [NSRC-1:0]    mem_hit_c;

  logic               stall_d,     stall_q;
  logic               forward_d,   forward_q;
  logic [NSRC-1:0]    src_fwd_d,   src_fwd_q;
  logic [NSRC*DW-1:0] src_data_d,  src_data_q;
  logic               hi_fwd_d,    hi_fwd_q;
  logic               lo_fwd_d,    lo_fwd_q;
  logic [DW-1:0]      hi_data_d,   hi_data_q;
  logic [DW-1:0]      lo_data_d,   lo_data_q;
  logic [CNT_W-1:0]   stall_cnt_d, stall_cnt_q;

  // Per-port index decode and producer match against EXE and MEM destinations
  for (genvar g = 0; g < NSRC; g++) begin : g_port
    assign idx_c[g]     = src_idx[g*AW +: AW];
    assign act_c[g]     = src_rena[g] & ((ZERO_REG == 0) | (idx_c[g] != '0));
    assign exe_hit_c[g] = exe_rd_wena & (exe_rd_idx == idx_c[g]);
    assign mem_hit_c[g] = mem_rd_wena & (mem_rd_idx == idx_c[g]);
  end

  // Next-state: per-port bypass/hazard, HI/LO bypass, flags, stall counter, flush override
  always_comb begin
    stall_d     = 1'b0;
    src_fwd_d   = '0;
    src_data_d  = src_data_q;
    hi_fwd_d    = 1'b0;
    lo_fwd_d    = 1'b0;
    hi_data_d   = hi_data_q;
    lo_data_d   = lo_data_q;
    forward_d   = 1'b0;
    stall_cnt_d = stall_cnt_q;

    // EXE holds the younger producer, so it is checked first
    for (int i = 0; i < NSRC; i++) begin
      if (act_c[i]) begin
        if (exe_hit_c[i]) begin
          if (exe_is_load) begin
            stall_d = 1'b1;
          end else begin
            src_fwd_d[i]            = 1'b1;
            src_data_d[i*DW +: DW]  = exe_rd_data;
          end
        end else if (mem_hit_c[i]) begin
          if (mem_rd_valid) begin
            src_fwd_d[i]            = 1'b1;
            src_data_d[i*DW +: DW]  = mem_rd_data;
          end else begin
            stall_d = 1'b1;
          end
        end
      end
    end

    if (HILO_EN != 0) begin
      if (id_rd_hi) begin
        if (exe_hi_wena) begin
          hi_fwd_d  = 1'b1;
          hi_data_d = exe_hi_data;
        end else if (mem_hi_wena) begin
          hi_fwd_d  = 1'b1;
          hi_data_d = mem_hi_data;
        end
      end
      if (id_rd_lo) begin
        if (exe_lo_wena) begin
          lo_fwd_d  = 1'b1;
          lo_data_d = exe_lo_data;
        end else if (mem_lo_wena) begin
          lo_fwd_d  = 1'b1;
          lo_data_d = mem_lo_data;
        end
      end
    end

    forward_d = (|src_fwd_d) | hi_fwd_d | lo_fwd_d | stall_d;

    if (stall_d && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Flush cancels all flags; data and counter hold
    if (flush_in) begin
      stall_d     = 1'b0;
      forward_d   = 1'b0;
      src_fwd_d   = '0;
      hi_fwd_d    = 1'b0;
      lo_fwd_d    = 1'b0;
      src_data_d  = src_data_q;
      hi_data_d   = hi_data_q;
      lo_data_d   = lo_data_q;
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Falling-edge state register with synchronous reset
  always_ff @(negedge clk_sig) begin
    if (rst_sig) begin
      stall_q     <= 1'b0;
      forward_q   <= 1'b0;
      src_fwd_q   <= '0;
      src_data_q  <= '0;
      hi_fwd_q    <= 1'b0;
      lo_fwd_q    <= 1'b0;
      hi_data_q   <= '0;
      lo_data_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      stall_q     <= stall_d;
      forward_q   <= forward_d;
      src_fwd_q   <= src_fwd_d;
      src_data_q  <= src_data_d;
      hi_fwd_q    <= hi_fwd_d;
      lo_fwd_q    <= lo_fwd_d;
      hi_data_q   <= hi_data_d;
      lo_data_q   <= lo_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_out     = stall_q;
  assign forward_out   = forward_q;
  assign src_fwd_out   = src_fwd_q;
  assign src_data_out  = src_data_q;
  assign hi_fwd_out    = hi_fwd_q;
  assign lo_fwd_out    = lo_fwd_q;
  assign hi_data_out   = hi_data_q;
  assign lo_data_out   = lo_data_q;
  assign stall_cnt_out = stall_cnt_q;

endmodule
